// File: rtl/edf_pkg.sv
// Purpose : shared types and defaults for the EDF interrupt arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package edf_pkg;

  localparam int NrSrcDefault   = 8;
  localparam int TsWidthDefault = 64;

  // Absolute deadline as produced by the gateway cells.
  typedef logic [TsWidthDefault-1:0] deadline_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2,
    CLAIM   = 2'd3
  } edf_arb_state_e;

endpackage

// File: rtl/edf_arbiter_if.sv
// Purpose : bundle between gateway array, EDF arbiter and core interrupt port.
// Latency : n/a (wiring only).
// Backpressure: irq_o is held until irq_ack_i or withdrawal of the pending flag.
//
// Signals:
//   ip_i      pending flag per source (gateway ip_o)
//   dl_i      packed deadlines, source k at [k*TsWidth +: TsWidth]
//   irq_ack_i core accepts the presented interrupt (one-cycle pulse)
//   irq_o     interrupt request to core
//   irq_id_o  index of presented source
//   irq_dl_o  deadline of presented source
//   claim_o   one-hot claim pulse back to the gateway cells
// Modports: master = arbiter side, slave = gateway/core side.
interface edf_arbiter_if #(
  parameter int NrSrc   = 8,
  parameter int TsWidth = 64,
  parameter int IdWidth = $clog2(NrSrc)
);

  logic [NrSrc-1:0]         ip_i;
  logic [NrSrc*TsWidth-1:0] dl_i;
  logic                     irq_ack_i;
  logic                     irq_o;
  logic [IdWidth-1:0]       irq_id_o;
  logic [TsWidth-1:0]       irq_dl_o;
  logic [NrSrc-1:0]         claim_o;

  modport master (
    input  ip_i, dl_i, irq_ack_i,
    output irq_o, irq_id_o, irq_dl_o, claim_o
  );

  modport slave (
    output ip_i, dl_i, irq_ack_i,
    input  irq_o, irq_id_o, irq_dl_o, claim_o
  );

endinterface

// File: rtl/edf_arbiter.sv
// Purpose : earliest-deadline-first arbiter; sequentially scans all sources,
//           presents the pending source with the earliest deadline to the core
//           and pulses claim_o back to that source's gateway on acknowledge.
// Latency : ip_i rising in IDLE -> irq_o high NrSrc+1 cycles later.
// Backpressure: irq_o held until irq_ack_i or the presented ip_i bit drops.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   bus            edf_arbiter_if.master (ip_i, dl_i, irq_ack_i in;
//                  irq_o, irq_id_o, irq_dl_o, claim_o out)
// Optional: define EDF_PREEMPT_EN to keep scanning while presenting and swap in
//           a strictly earlier deadline at the end of each background pass.
module edf_arbiter
  import edf_pkg::*;
#(
  parameter int NrSrc   = NrSrcDefault,
  parameter int TsWidth = TsWidthDefault,
  parameter int IdWidth = $clog2(NrSrc)
) (
  input logic         clk_i,
  input logic         rst_ni,
  edf_arbiter_if.master bus
);

  edf_arb_state_e     state;
  logic [IdWidth-1:0] idx;
  logic               best_vld;
  logic [IdWidth-1:0] best_id;
  logic [TsWidth-1:0] best_dl;

  // Single comparator datapath shared by the foreground and background scans.
  logic [TsWidth-1:0] cand_dl;
  logic               take;
  logic               nxt_vld;
  logic [IdWidth-1:0] nxt_id;
  logic [TsWidth-1:0] nxt_dl;
  logic               scan_last;
  logic [NrSrc-1:0]   claim_vec;

  always_comb begin
    cand_dl   = bus.dl_i[int'(idx)*TsWidth +: TsWidth];
    // Strict less-than: on a tie the earlier (lower) index is kept.
    take      = bus.ip_i[idx] && (!best_vld || (cand_dl < best_dl));
    nxt_vld   = best_vld | bus.ip_i[idx];
    nxt_id    = take ? idx : best_id;
    nxt_dl    = take ? cand_dl : best_dl;
    scan_last = (idx == IdWidth'(NrSrc - 1));
    claim_vec = '0;
    claim_vec[bus.irq_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      idx          <= '0;
      best_vld     <= 1'b0;
      best_id      <= '0;
      best_dl      <= '0;
      bus.irq_o    <= 1'b0;
      bus.irq_id_o <= '0;
      bus.irq_dl_o <= '0;
      bus.claim_o  <= '0;
    end else begin
      // claim_o is a pulse: it is only ever set on the PRESENT->CLAIM edge.
      bus.claim_o <= '0;
      case (state)
        IDLE: begin
          idx      <= '0;
          best_vld <= 1'b0;
          if (|bus.ip_i) state <= SCAN;
        end

        SCAN: begin
          best_vld <= nxt_vld;
          best_id  <= nxt_id;
          best_dl  <= nxt_dl;
          idx      <= idx + 1'b1;
          if (scan_last) begin
            // Last index folds into the decision combinationally so the
            // winner is presented on the same edge the pass completes.
            idx      <= '0;
            best_vld <= 1'b0;
            if (nxt_vld) begin
              state        <= PRESENT;
              bus.irq_o    <= 1'b1;
              bus.irq_id_o <= nxt_id;
              bus.irq_dl_o <= nxt_dl;
            end else begin
              state <= IDLE;
            end
          end
        end

        PRESENT: begin
          if (!bus.ip_i[bus.irq_id_o]) begin
            // Withdrawal beats a same-cycle ack: no claim is issued.
            bus.irq_o <= 1'b0;
            state     <= IDLE;
          end else if (bus.irq_ack_i) begin
            bus.irq_o   <= 1'b0;
            bus.claim_o <= claim_vec;
            state       <= CLAIM;
          end
`ifdef EDF_PREEMPT_EN
          else begin
            best_vld <= nxt_vld;
            best_id  <= nxt_id;
            best_dl  <= nxt_dl;
            idx      <= idx + 1'b1;
            if (scan_last) begin
              idx      <= '0;
              best_vld <= 1'b0;
              if (nxt_vld && (nxt_dl < bus.irq_dl_o)) begin
                bus.irq_id_o <= nxt_id;
                bus.irq_dl_o <= nxt_dl;
              end
            end
          end
`endif
        end

        CLAIM: begin
          // Gateway drops its ip on this edge; IDLE then sees the cleared flag.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
